mem_responder: RTL
==================

# mem_responder

Wait-state memory responder serving the multi-cycle CPU's unified instruction/data port over a req/ack handshake. It is the target side of the address/write-data/write-enable/read-data path the datapath drives. It models a slow synchronous RAM: each request is captured, held for a programmable number of wait cycles, committed, then acknowledged for exactly one cycle. This lets the control FSM be exercised against non-zero memory latency.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two, ≥4); AW = clog2(DEPTH_WORDS)
- LATENCY, 2, wait cycles between request capture and commit (integer ≥1)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; asserting it (0) clears state immediately
- req  input  1  request strobe from the initiator, sampled only in IDLE
- we  input  1  1 = write, 0 = read; captured with req
- addr  input  32  byte address; word index = addr[AW+1:2]
- wdata  input  32  write data; captured with req
- ack  output  1  one-cycle completion pulse
- rdata  output  32  registered read data; valid in the ack cycle, held until the next read commits
- busy  output  1  high while a request is in flight (WAIT or RESP)
- err  output  1  access-error flag, valid with ack (see Configuration)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On req=1, capture we/addr/wdata into internal registers.
  - Load cnt = LATENCY-1 and go to WAIT. Otherwise stay in IDLE.
- WAIT:
  - If cnt≠0, decrement cnt.
  - If cnt=0, commit the access on this edge and go to RESP:
    - write: array[idx] ← captured wdata; rdata unchanged.
    - read: rdata ← array[idx].
- RESP: ack=1 (and err if applicable) for this single cycle, then go to IDLE unconditionally.
- Only captured values are used. Changes to req/we/addr/wdata after capture are ignored.
- If req drops during WAIT, the access still completes and ack still pulses.
- A req held high through RESP is sampled again in the following IDLE cycle and starts a new access. The initiator must drop req in the ack cycle to avoid a duplicate access.
- Address bits [1:0] are ignored, and bits above AW+1 alias (unless the macro is enabled).
- The array is not cleared by reset. Its contents are undefined at power-up and preserved across reset.

## Timing
- Reset values: ack=0, busy=0, err=0, rdata=32'h0, state=IDLE, cnt=0.
- Latency: req high in IDLE during cycle 0 → WAIT in cycles 1..LATENCY → commit at the end of cycle LATENCY → ack=1 in cycle LATENCY+1.
- Throughput: one access per LATENCY+2 cycles when req is held continuously.
- busy=1 from cycle 1 through the ack cycle inclusive, and 0 in IDLE.
- A read of an address written by the immediately preceding access returns the new data; a write always commits before its ack.
- Reset mid-operation:
  - Asserting reset in WAIT aborts the access; an uncommitted write is discarded.
  - Asserting reset in RESP drops ack asynchronously.
  - The first request after reset deassertion is sampled on the first rising edge with reset=1.

## Configuration
- Macro: MEM_RESP_ERR_EN.
- Defined:
  - An access is in error if addr[1:0]≠0 or addr ≥ 4·DEPTH_WORDS.
  - An erroring write is suppressed (array unchanged).
  - An erroring read leaves rdata unchanged.
  - err=1 in the ack cycle only. Timing and the handshake are identical to non-error accesses.
- Not defined: err is tied to 0, low address bits are ignored, and upper bits alias into the array.

## Test plan
- Write then read, LATENCY=2: write addr=0x10, wdata=0xCAFEF00D with req in cycle 0 → ack in cycle 3. Read addr=0x10 → ack 3 cycles after its req, rdata=0xCAFEF00D, err=0.
- LATENCY=1 and LATENCY=5 builds: single read → ack exactly LATENCY+1 cycles after req; busy high for LATENCY+1 cycles; ack width exactly 1.
- Request drop: req pulsed for one cycle with a write of 0x12345678 to 0x20, then addr/wdata changed to garbage → ack still pulses. A read of 0x20 returns 0x12345678.
- Back-to-back: req held high for 3 accesses with LATENCY=2 → acks at cycles 3, 7, 11; rdata from the last read only changes at read commits.
- Reset mid-write: write 0xFFFFFFFF to 0x40 (previously 0x00000001), then assert reset during WAIT → ack=0, busy=0 immediately. After release, a read of 0x40 returns 0x00000001.
- MEM_RESP_ERR_EN defined, DEPTH_WORDS=256:
  - Write addr=0x402 → ack with err=1, memory unchanged.
  - Read addr=0x400 → err=1, rdata held.
  - Read addr=0x3FC → err=0.

Source files
------------

// File: rtl/mem_responder_if.sv
// ============================================================================
//  Module      : mem_responder_if
//  Description : Request/acknowledge bus between the CPU memory port
//                (master) and the wait-state memory responder (slave).
//  Signals     : req    - request strobe (master -> slave)
//                we     - 1 = write, 0 = read (master -> slave)
//                addr   - 32-bit byte address (master -> slave)
//                wdata  - 32-bit write data (master -> slave)
//                ack    - one-cycle completion pulse (slave -> master)
//                rdata  - registered read data (slave -> master)
//                busy   - access in flight (slave -> master)
//                err    - access error, valid with ack (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;
   logic        busy;
   logic        err;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata, busy, err
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata, busy, err
   );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
//  Module      : mem_responder
//  Description : Wait-state synchronous RAM model. A request is captured in
//                IDLE, held for LATENCY wait cycles, committed, and then
//                acknowledged for exactly one cycle.
//  Parameters  : DEPTH_WORDS - number of 32-bit words (power of two, >= 4)
//                LATENCY     - wait cycles between capture and commit (>= 1)
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-low reset
//                bus   - mem_responder_if.slave (req/we/addr/wdata in,
//                        ack/rdata/busy/err out)
//  Options     : MEM_RESP_ERR_EN - when defined, misaligned or out-of-range
//                addresses are flagged with err and have no side effect.
//                When undefined, err is 0 and upper address bits alias.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic            clk,
   input  logic            reset,
   mem_responder_if.slave  bus
);

   localparam int AW = $clog2(DEPTH_WORDS);
   // Counter only ever holds LATENCY-1 down to 0.
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic            we_q;
   logic [AW-1:0]   idx_q;
   logic [31:0]     wdata_q;
   logic            err_pend_q;
   logic            ack_q;
   logic            busy_q;
   logic            err_q;
   logic [31:0]     rdata_q;

   // Array has no reset: contents survive reset and are undefined at power-up.
   logic [31:0]     mem_q [DEPTH_WORDS];

   logic            w_req_err;
   logic            w_commit_wr;

`ifdef MEM_RESP_ERR_EN
   localparam logic [32:0] c_ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
   // Error is decided at capture time so later bus changes cannot affect it.
   assign w_req_err = (bus.addr[1:0] != 2'b00) ||
                      ({1'b0, bus.addr} >= c_ADDR_LIMIT);
`else
   assign w_req_err = 1'b0;
`endif

   // Write commits on the last WAIT edge; an erroring write is suppressed.
   assign w_commit_wr = (state_q == S_WAIT) && (cnt_q == '0) &&
                        we_q && !err_pend_q;

   always_ff @(posedge clk) begin
      if (w_commit_wr) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         err_pend_q <= 1'b0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               ack_q  <= 1'b0;
               err_q  <= 1'b0;
               busy_q <= 1'b0;
               if (bus.req) begin
                  we_q       <= bus.we;
                  idx_q      <= bus.addr[AW+1:2];
                  wdata_q    <= bus.wdata;
                  err_pend_q <= w_req_err;
                  cnt_q      <= CW'(LATENCY - 1);
                  busy_q     <= 1'b1;
                  state_q    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  // Read commit; erroring reads keep the previous rdata.
                  if (!we_q && !err_pend_q) begin
                     rdata_q <= mem_q[idx_q];
                  end
                  ack_q   <= 1'b1;
                  err_q   <= err_pend_q;
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ack   = ack_q;
   assign bus.busy  = busy_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;

endmodule

`default_nettype wire
